// File: rtl/video_pkg.sv
// Shared video timing definitions for the 480x272 RGB LCD pipeline.
package video_pkg;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_H_FP     = 2;
  localparam int LCD_H_SYNC   = 41;
  localparam int LCD_H_BP     = 2;
  localparam int LCD_H_TOTAL  = LCD_H_ACTIVE + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;

  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_V_FP     = 2;
  localparam int LCD_V_SYNC   = 10;
  localparam int LCD_V_BP     = 2;
  localparam int LCD_V_TOTAL  = LCD_V_ACTIVE + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;

  localparam int LCD_LOCK_CYC = 1024;

  // Drive level of a sync line given whether it is asserted and its active polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Synchronises the PLL lock and qualifies it as stable after LOCK_CYC high cycles.
module lock_filter #(
  parameter int LOCK_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic lock,
  output logic lock_ok
);

  localparam int CW = $clog2(LOCK_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CYC - 1);

  logic          lock_meta;
  logic          lock_s;
  logic [CW-1:0] cnt;
  logic          ok_q;

  // Two-flop synchroniser, then a saturating stable-lock counter that any low sample clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      cnt       <= '0;
      ok_q      <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
      if (!lock_s)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      ok_q <= lock_s && (cnt == CNT_MAX);
    end
  end

  // Qualified lock drops as soon as the synchronised lock does, so loss is seen without extra delay.
  assign lock_ok = ok_q & lock_s;

endmodule

// File: rtl/lcd_timing_gen.sv
// Pixel-clock video timing generator: lock-qualified FSM, h/v counters, registered sync/de/coords.
module lcd_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = LCD_H_ACTIVE,
  parameter int   H_FP     = LCD_H_FP,
  parameter int   H_SYNC   = LCD_H_SYNC,
  parameter int   H_BP     = LCD_H_BP,
  parameter int   V_ACTIVE = LCD_V_ACTIVE,
  parameter int   V_FP     = LCD_V_FP,
  parameter int   V_SYNC   = LCD_V_SYNC,
  parameter int   V_BP     = LCD_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   LOCK_CYC = LCD_LOCK_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 512) begin : g_bad_timing
      $error("lcd_timing_gen: H_TOTAL must be <= 1024 and V_TOTAL <= 512");
    end
  endgenerate

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic       lock_ok;
  state_t     state;
  state_t     state_n;
  logic       run_go;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       de_c;

  lock_filter #(
    .LOCK_CYC (LOCK_CYC)
  ) u_lock_filter (
    .clk     (clk),
    .rst     (rst),
    .lock    (lock),
    .lock_ok (lock_ok)
  );

  // Next-state: enter RUN on qualified lock, fall back to WAIT_LOCK as soon as it is lost.
  always_comb begin
    state_n = state;
    case (state)
      WAIT_LOCK: if (lock_ok)  state_n = RUN;
      RUN:       if (!lock_ok) state_n = WAIT_LOCK;
      default:                 state_n = WAIT_LOCK;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LOCK;
    else     state <= state_n;
  end

  // Counters advance only while RUN persists; the entry cycle presents the origin, any exit clears.
  assign run_go = (state == RUN) && (state_n == RUN);

  // Horizontal/vertical position counters; an abandoned frame restarts from the origin.
  always_ff @(posedge clk) begin
    if (rst || !run_go) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign de_c = (hcnt < H_ACT) && (vcnt < V_ACT);

  // Output stage: one register from the counter state, idle whenever the generator is not running.
  always_ff @(posedge clk) begin
    if (rst || !run_go) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= sync_level((hcnt >= HS_BEG) && (hcnt < HS_END), SYNC_POL);
      vsync       <= sync_level((vcnt >= VS_BEG) && (vcnt < VS_END), SYNC_POL);
      de          <= de_c;
      x           <= de_c ? hcnt : 10'd0;
      y           <= de_c ? vcnt[8:0] : 9'd0;
      line_start  <= (hcnt == 10'd0);
      frame_start <= (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: default 480x272 timing plus a reduced, inverted-polarity instance.
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic lock;

  // Default-timing instance (active-low syncs).
  logic       hs_d, vs_d, de_d, ls_d, fs_d, run_d;
  logic [9:0] x_d;
  logic [8:0] y_d;

  // Reduced-timing instance (active-high syncs): H 16+2+4+3=25, V 6+1+2+1=10, lock wait 8.
  logic       hs_s, vs_s, de_s, ls_s, fs_s, run_s;
  logic [9:0] x_s;
  logic [8:0] y_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lcd_timing_gen u_dut (
    .clk(clk), .rst(rst), .lock(lock),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d), .running(run_d)
  );

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .LOCK_CYC(8)
  ) u_dut_small (
    .clk(clk), .rst(rst), .lock(lock),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s), .running(run_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Checks every output of the default instance against its idle/reset values.
  task automatic chk_idle(input string tag);
    chk({tag, "_run"}, 32'(run_d), 0);
    chk({tag, "_de"},  32'(de_d),  0);
    chk({tag, "_hs"},  32'(hs_d),  1);
    chk({tag, "_vs"},  32'(vs_d),  1);
    chk({tag, "_x"},   32'(x_d),   0);
    chk({tag, "_y"},   32'(y_d),   0);
    chk({tag, "_ls"},  32'(ls_d),  0);
    chk({tag, "_fs"},  32'(fs_d),  0);
  endtask

  // Counts edges from now until the default instance reports running.
  task automatic wait_running(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!run_d && n < 2000);
  endtask

  initial begin
    int n;
    int w;
    int hs_low, hs_err, de_err, x_err;
    int hc, vc, s_err, s_de, s_hs, s_vs;
    int run_seen;

    rst  = 1'b1;
    lock = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_small_hs", 32'(hs_s), 0);
    chk("reset_small_vs", 32'(vs_s), 0);

    // Lock qualification latency and first frame origin.
    rst = 1'b0;
    wait_running(n);
    chk("run_latency", n, 1027);
    chk("run_fs_not_yet", 32'(fs_d), 0);
    @(negedge clk);
    chk("first_fs", 32'(fs_d), 1);
    chk("first_ls", 32'(ls_d), 1);
    chk("first_de", 32'(de_d), 1);

    // First line of the default instance: hsync placement, de and x.
    hs_low = 0; hs_err = 0; de_err = 0; x_err = 0;
    for (int i = 0; i < 525; i++) begin
      if (!hs_d) hs_low++;
      if (hs_d !== !((i >= 482) && (i < 523))) hs_err++;
      if (de_d !== (i < 480)) de_err++;
      if (x_d !== ((i < 480) ? 10'(i) : 10'd0)) x_err++;
      if (vs_d !== 1'b1) hs_err++;
      @(negedge clk);
    end
    chk("line_hs_low", hs_low, 41);
    chk("line_hs_err", hs_err, 0);
    chk("line_de_err", de_err, 0);
    chk("line_x_err", x_err, 0);
    chk("line2_ls", 32'(ls_d), 1);
    chk("line2_fs", 32'(fs_d), 0);

    // One full frame of the reduced instance against a cycle model.
    w = 0;
    while (!fs_s && w < 300) begin @(negedge clk); w++; end
    chk("small_fs_seen", 32'(fs_s), 1);
    hc = 0; vc = 0; s_err = 0; s_de = 0; s_hs = 0; s_vs = 0;
    for (int i = 0; i < 250; i++) begin
      logic e_de;
      e_de = (hc < 16) && (vc < 6);
      if (de_s) s_de++;
      if (hs_s) s_hs++;
      if (vs_s) s_vs++;
      if (de_s !== e_de) s_err++;
      if (hs_s !== ((hc >= 18) && (hc < 22))) s_err++;
      if (vs_s !== ((vc >= 7) && (vc < 9))) s_err++;
      if (x_s !== (e_de ? 10'(hc) : 10'd0)) s_err++;
      if (y_s !== (e_de ? 9'(vc) : 9'd0)) s_err++;
      if (ls_s !== (hc == 0)) s_err++;
      if (fs_s !== ((hc == 0) && (vc == 0))) s_err++;
      hc++;
      if (hc == 25) begin
        hc = 0;
        vc = (vc == 9) ? 0 : vc + 1;
      end
      @(negedge clk);
    end
    chk("small_err", s_err, 0);
    chk("small_de_cnt", s_de, 96);
    chk("small_hs_cnt", s_hs, 40);
    chk("small_vs_cnt", s_vs, 50);
    chk("small_fs_period", 32'(fs_s), 1);

    // Lock drop at y=100, x=200.
    w = 0;
    while (!(de_d && y_d == 9'd100 && x_d == 10'd200) && w < 60000) begin
      @(negedge clk);
      w++;
    end
    chk("reach_y100_x200", 32'(de_d && y_d == 9'd100 && x_d == 10'd200), 1);
    lock = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_run_hold", 32'(run_d), 1);
    @(negedge clk);
    chk_idle("drop");
    lock = 1'b1;
    wait_running(n);
    chk("relock_latency", n, 1027);
    @(negedge clk);
    chk("relock_fs", 32'(fs_d), 1);
    chk("relock_de", 32'(de_d), 1);
    chk("relock_x", 32'(x_d), 0);
    chk("relock_y", 32'(y_d), 0);

    // Single-cycle reset mid active line.
    w = 0;
    while (!(de_d && x_d == 10'd100) && w < 600) begin @(negedge clk); w++; end
    chk("reach_x100", 32'(de_d && x_d == 10'd100), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_pulse");
    rst = 1'b0;
    wait_running(n);
    chk("rst_relock_latency", n, 1027);

    // Lock glitching low for one cycle every 500 cycles never qualifies.
    lock = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_start_idle", 32'(run_d), 0);
    run_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      lock = ((i % 500) == 499) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (run_d) run_seen++;
    end
    chk("glitch_run_seen", run_seen, 0);
    lock = 1'b1;
    wait_running(n);
    chk("glitch_recover", 32'(run_d), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
